// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_alu : handshaked multi-cycle ALU (legacy ops, xor/sltu, iterative    |
// |           shifts, shift-add multiply)                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_alu #(
   parameter int XLEN   = 64,
   parameter int MUL_EN = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      alu_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int c_SW = $clog2(XLEN);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_SHIFT = 2'd1;
   localparam logic [1:0] c_MUL   = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [1:0] c_K_SLL = 2'd0;
   localparam logic [1:0] c_K_SRL = 2'd1;
   localparam logic [1:0] c_K_SRA = 2'd2;

   localparam logic [c_SW:0] c_CNT_ONE = (c_SW+1)'(1);
   localparam logic [c_SW:0] c_CNT_MUL = (c_SW+1)'(XLEN);

   logic [1:0]      state_q,  state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q,   zero_d;
   logic [c_SW:0]   count_q,  count_d;
   logic [XLEN-1:0] work_q,   work_d;
   logic [XLEN-1:0] mcand_q,  mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [1:0]      kind_q,   kind_d;

   logic [XLEN-1:0] w_bx;
   logic [XLEN-1:0] w_sum;
   logic [XLEN-1:0] w_single;
   logic [c_SW-1:0] w_shamt;
   logic            w_is_shift;
   logic            w_is_mul;
   logic [XLEN-1:0] w_shift_nxt;
   logic [XLEN-1:0] w_acc_nxt;

   // Legacy encoding: bit2 both inverts b and supplies the carry-in, giving a-b.
   assign w_bx    = alu_op[2] ? ~b : b;
   assign w_sum   = a + w_bx + {{(XLEN-1){1'b0}}, alu_op[2]};
   assign w_shamt = b[c_SW-1:0];

   assign w_is_shift = alu_op[3] &&
                       (alu_op[2:0] == 3'b010 || alu_op[2:0] == 3'b011 ||
                        alu_op[2:0] == 3'b100);
   assign w_is_mul   = (MUL_EN != 0) && (alu_op == 4'b1101);

   always_comb begin
      w_single = '0;
      if (!alu_op[3]) begin
         case (alu_op[1:0])
            2'b00:   w_single = a & w_bx;
            2'b01:   w_single = a | w_bx;
            2'b10:   w_single = w_sum;
            default: w_single = {{(XLEN-1){1'b0}}, w_sum[XLEN-1]};
         endcase
      end else begin
         case (alu_op[2:0])
            3'b000:  w_single = a ^ b;
            3'b001:  w_single = {{(XLEN-1){1'b0}}, (a < b)};
            default: w_single = '0;
         endcase
      end
   end

   always_comb begin
      case (kind_q)
         c_K_SLL: w_shift_nxt = {work_q[XLEN-2:0], 1'b0};
         c_K_SRL: w_shift_nxt = {1'b0, work_q[XLEN-1:1]};
         default: w_shift_nxt = {work_q[XLEN-1], work_q[XLEN-1:1]};
      endcase
   end

   assign w_acc_nxt = mplier_q[0] ? (work_q + mcand_q) : work_q;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      count_d  = count_q;
      work_d   = work_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      kind_d   = kind_q;
      case (state_q)
         c_IDLE: begin
            if (in_valid) begin
               if (w_is_shift) begin
                  kind_d = alu_op[2] ? c_K_SRA : (alu_op[0] ? c_K_SRL : c_K_SLL);
                  if (w_shamt == '0) begin
                     result_d = a;
                     zero_d   = (a == '0);
                     state_d  = c_DONE;
                  end else begin
                     work_d  = a;
                     count_d = {1'b0, w_shamt};
                     state_d = c_SHIFT;
                  end
               end else if (w_is_mul) begin
                  work_d   = '0;
                  mcand_d  = a;
                  mplier_d = b;
                  count_d  = c_CNT_MUL;
                  state_d  = c_MUL;
               end else begin
                  result_d = w_single;
                  zero_d   = (w_single == '0);
                  state_d  = c_DONE;
               end
            end
         end
         c_SHIFT: begin
            work_d  = w_shift_nxt;
            count_d = count_q - c_CNT_ONE;
            if (count_q == c_CNT_ONE) begin
               result_d = w_shift_nxt;
               zero_d   = (w_shift_nxt == '0);
               state_d  = c_DONE;
            end
         end
         c_MUL: begin
            work_d   = w_acc_nxt;
            mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
            count_d  = count_q - c_CNT_ONE;
            if (count_q == c_CNT_ONE) begin
               result_d = w_acc_nxt;
               zero_d   = (w_acc_nxt == '0);
               state_d  = c_DONE;
            end
         end
         default: begin
            if (out_ready) begin
               state_d = c_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= c_IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         count_q  <= '0;
         work_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         kind_q   <= c_K_SLL;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         count_q  <= count_d;
         work_q   <= work_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         kind_q   <= kind_d;
      end
   end

   assign in_ready  = (state_q == c_IDLE);
   assign out_valid = (state_q == c_DONE);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule
`default_nettype wire
